// File: rtl/key_pkg.sv
// Shared HID usage codes and keycode type for every key-input source.
// Latency: none (constants, types and a pure function).
// Backpressure: not applicable.
package key_pkg;

    typedef logic [11:0] keycode_t;

    localparam keycode_t   KEY_NONE  = 12'h000;

    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_Q     = 8'h14;
    localparam logic [7:0] HID_E     = 8'h08;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_Z     = 8'h1D;
    localparam logic [7:0] HID_X     = 8'h1B;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DECODE
    } rx_state_t;

    function automatic logic is_supported_key(input logic [7:0] code);
        case (code)
            HID_W, HID_S, HID_A, HID_D, HID_Q, HID_E,
            HID_UP, HID_DOWN, HID_LEFT, HID_RIGHT, HID_Z, HID_X:
                is_supported_key = 1'b1;
            default:
                is_supported_key = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserializer: synchronizer, baud counter and START/DATA/STOP/DECODE FSM.
// Latency: byte_vld is high for the DECODE cycle, one Clk after the stop-bit sample cycle.
// Backpressure: none; byte_vld and frame_err are single-cycle pulses.
module uart_rx_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);
    import key_pkg::*;

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);

    logic            rx_meta, rx_s;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            armed_q, armed_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            armed_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            armed_q <= armed_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        armed_d = armed_q;
        ferr_d  = 1'b0;
        case (state_q)
            // A start edge only counts after the line has been seen high,
            // so a held break cannot retrigger frames.
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RX_DECODE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DECODE: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_byte   = sh_q;
    assign byte_vld  = (state_q == RX_DECODE);
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_keycode_rx.sv
// UART key receiver: decodes HID bytes onto the shared keycode bus, with hold-timeout auto-release.
// Latency: keycode/keycode_vld update on the edge ending DECODE, 2 Clk after the stop-bit sample.
// Backpressure: none; keycode_vld, frame_err and unknown_key are single-cycle pulses.
module uart_keycode_rx #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        rx,
    output logic [11:0] keycode,
    output logic        keycode_vld,
    output logic        frame_err,
    output logic        unknown_key
);
    import key_pkg::*;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [7:0]    rx_byte;
    logic          byte_vld;
    logic          accept;
    logic [HW-1:0] hold_cnt;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .Clk       (Clk),
        .Reset     (Reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    // 0x00 is an explicit release and is written like any supported code.
    assign accept = byte_vld && ((rx_byte == 8'h00) || is_supported_key(rx_byte));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keycode     <= KEY_NONE;
            keycode_vld <= 1'b0;
            unknown_key <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            keycode_vld <= accept;
            unknown_key <= byte_vld && !accept;
            if (accept) begin
                keycode  <= {4'h0, rx_byte};
                hold_cnt <= '0;
            end else if (keycode == KEY_NONE) begin
                hold_cnt <= '0;
            end else if ((HOLD_CYCLES != 0) && (hold_cnt != HOLD_MAX)) begin
                // Unknown bytes fall through here so they never extend a hold.
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_MAX - 1'b1) begin
                    keycode <= KEY_NONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_keycode_rx.sv
// Scoreboard bench for uart_keycode_rx: directed frames push expected events, a monitor pops and compares.
module tb_uart_keycode_rx;

    localparam int EV_NONE = 0;
    localparam int EV_VLD  = 1;
    localparam int EV_FERR = 2;
    localparam int EV_UNK  = 3;
    localparam int EV_REL  = 4;

    typedef struct {
        int          kind;
        logic [11:0] code;
        int          cyc;
    } ev_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        rx;
    logic [11:0] keycode;
    logic        keycode_vld;
    logic        frame_err;
    logic        unknown_key;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    uart_keycode_rx #(
        .CLK_FREQ    (1000),
        .BAUD        (100),
        .HOLD_CYCLES (500)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .rx          (rx),
        .keycode     (keycode),
        .keycode_vld (keycode_vld),
        .frame_err   (frame_err),
        .unknown_key (unknown_key)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every pulse, and any keycode change without a pulse, is one scoreboard event.
    logic [11:0] prev_kc = 12'h000;
    int          kind;
    ev_t         e;
    always @(negedge Clk) begin
        if (Reset) begin
            prev_kc = keycode;
        end else begin
            kind = EV_NONE;
            if (keycode_vld)             kind = EV_VLD;
            else if (frame_err)          kind = EV_FERR;
            else if (unknown_key)        kind = EV_UNK;
            else if (keycode != prev_kc) kind = EV_REL;
            if (kind != EV_NONE) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event kind=%0d keycode=%h cyc=%0d", kind, keycode, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.code != keycode || e.cyc != cyc ||
                        $countones({keycode_vld, frame_err, unknown_key}) > 1) begin
                        errors++;
                        $display("FAIL event got kind=%0d keycode=%h cyc=%0d pulses=%b want kind=%0d keycode=%h cyc=%0d",
                                 kind, keycode, cyc, {keycode_vld, frame_err, unknown_key},
                                 e.kind, e.code, e.cyc);
                    end
                end
            end
            prev_kc = keycode;
        end
    end

    task automatic expect_ev(input int k, input logic [11:0] code, input int at);
        ev_t ev;
        ev.kind = k;
        ev.code = code;
        ev.cyc  = at;
        exp_q.push_back(ev);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Drives one 100-cycle frame starting now; returns aligned just after the next bit boundary.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(10);
        end
    endtask

    int s;

    initial begin
        Reset = 1'b1;
        rx    = 1'b1;
        idle(3);
        chk("reset_keycode", keycode, 12'h000);
        chk("reset_vld", {11'd0, keycode_vld}, 12'h000);
        chk("reset_ferr", {11'd0, frame_err}, 12'h000);
        chk("reset_unk", {11'd0, unknown_key}, 12'h000);
        Reset = 1'b0;
        idle(5);

        // Test 1 and 2: 0x1A, then 0x52 and 0x00 back-to-back.
        s = cyc;
        expect_ev(EV_VLD, 12'h01A, s + 99);
        send_frame(8'h1A, 1'b1);
        chk("t1_keycode", keycode, 12'h01A);
        s = cyc;
        expect_ev(EV_VLD, 12'h052, s + 99);
        expect_ev(EV_VLD, 12'h000, s + 199);
        send_frame(8'h52, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(5);
        chk("t2_release", keycode, 12'h000);

        // Test 3 and 4: unknown byte and bad stop bit both leave 0x07 held.
        s = cyc;
        expect_ev(EV_VLD, 12'h007, s + 99);
        send_frame(8'h07, 1'b1);
        s = cyc;
        expect_ev(EV_UNK, 12'h007, s + 99);
        send_frame(8'h29, 1'b1);
        s = cyc;
        expect_ev(EV_FERR, 12'h007, s + 98);
        send_frame(8'h04, 1'b0);
        rx = 1'b1;
        idle(20);
        chk("t4_held_after_err", keycode, 12'h007);
        s = cyc;
        expect_ev(EV_VLD, 12'h016, s + 99);
        expect_ev(EV_REL, 12'h000, s + 599);
        send_frame(8'h16, 1'b1);
        chk("t4_keycode", keycode, 12'h016);
        idle(510);
        chk("t4_auto_release", keycode, 12'h000);

        // Test 5: auto-release 500 after vld, unaffected by an unknown byte; resends keep it held.
        s = cyc;
        expect_ev(EV_VLD, 12'h04F, s + 99);
        send_frame(8'h4F, 1'b1);
        idle(100);
        expect_ev(EV_UNK, 12'h04F, cyc + 99);
        expect_ev(EV_REL, 12'h000, s + 599);
        send_frame(8'h29, 1'b1);
        idle(310);
        chk("t5_release", keycode, 12'h000);
        s = cyc;
        expect_ev(EV_VLD, 12'h04F, s + 99);
        send_frame(8'h4F, 1'b1);
        idle(200);
        expect_ev(EV_VLD, 12'h04F, s + 399);
        send_frame(8'h4F, 1'b1);
        idle(200);
        expect_ev(EV_VLD, 12'h04F, s + 699);
        expect_ev(EV_REL, 12'h000, s + 1199);
        send_frame(8'h4F, 1'b1);
        chk("t5_still_held", keycode, 12'h04F);
        idle(510);
        chk("t5_final_release", keycode, 12'h000);

        // Test 6: glitch, reset mid-frame, then a clean frame.
        s = cyc;
        expect_ev(EV_VLD, 12'h014, s + 99);
        send_frame(8'h14, 1'b1);
        idle(10);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        chk("t6_glitch_held", keycode, 12'h014);
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(10);
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(10);
        Reset = 1'b1;
        idle(2);
        chk("t6_rst_keycode", keycode, 12'h000);
        chk("t6_rst_pulses", {9'd0, keycode_vld, frame_err, unknown_key}, 12'h000);
        idle(3);
        Reset = 1'b0;
        idle(20);
        s = cyc;
        expect_ev(EV_VLD, 12'h01B, s + 99);
        expect_ev(EV_REL, 12'h000, s + 599);
        send_frame(8'h1B, 1'b1);
        chk("t6_keycode", keycode, 12'h01B);
        idle(510);
        chk("t6_release", keycode, 12'h000);

        chk("pending_events", 12'(exp_q.size()), 12'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
